conv5x5_frame_ctrl: RTL and testbench
=====================================

# conv5x5_frame_ctrl

Frame sequencer for the per-channel 5x5 convolution engines. Accepts the pixel stream through a valid/ready handshake, drives the engines' `data_valid` strobe, tracks raster position, and produces a window-valid tag aligned to the engines' fixed pipeline latency. The tag marks only outputs computed from a fully populated 5x5 window. It also provides start/busy/done frame control. The block sits between the pixel source and the three-channel conv wrapper. Pixel data bypasses it; only control passes through it.

## Interface
- `IMG_W`, 640, pixels per line (≥ K)
- `IMG_H`, 480, lines per frame (≥ K)
- `K`, 5, kernel size; warm-up is K-1 rows and K-1 columns
- `CW`, 12, x/y counter width; must satisfy 2^CW > max(IMG_W, IMG_H)
- `PIPE_LAT`, 4, engine latency in clock cycles from `conv_en` to result (≥ 1)

Ports:
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request to begin a frame; sampled only in IDLE
- `abort` in 1: synchronous abort; returns to IDLE next cycle from any state
- `s_valid` in 1: upstream pixel valid
- `s_ready` out 1: block can accept a pixel
- `conv_en` out 1: data_valid strobe to the conv engines, equal to `s_valid & s_ready`
- `win_valid` out 1: engine output of this cycle is a full-window result
- `win_sof` out 1: with first `win_valid` of frame
- `win_eol` out 1: with last `win_valid` of each output line
- `win_eof` out 1: with last `win_valid` of frame
- `x`, `y` out CW each: raster position of the next pixel to be accepted
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse at frame completion

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: when `start`=1, clear x/y and go to RUN.
  - RUN: `s_ready`=1. On accept, x increments. When x=IMG_W-1, x wraps to 0 and y increments. On accept of (IMG_W-1, IMG_H-1), go to FLUSH.
  - FLUSH: `s_ready`=0. A flush counter counts PIPE_LAT cycles, then the FSM goes to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `abort`=1 overrides everything. Next state is IDLE, x/y clear, and the tag pipeline is flushed to 0. The `done` pulse is suppressed.
- `start` outside IDLE is ignored. `start` and `abort` asserted in the same cycle: `abort` wins.
- Tag generation on each accept, using x/y before increment:
  - v = (x ≥ K-1) & (y ≥ K-1)
  - sof = v & x=K-1 & y=K-1
  - eol = v & x=IMG_W-1
  - eof = v & x=IMG_W-1 & y=IMG_H-1
- The {v, sof, eol, eof} tag enters a PIPE_LAT-deep shift register that advances every cycle. Non-accept cycles insert zeros.
- `win_*` outputs are the final stage of that shift register.
- Frame output count is (IMG_W-K+1)·(IMG_H-K+1) `win_valid` pulses.
- There is no downstream backpressure. Consumers must sink one result per clock.

## Timing
- Reset values: state IDLE, `s_ready`=0, `conv_en`=0, all `win_*`=0, x=y=0, `busy`=0, `done`=0, flush counter 0, tag pipeline all 0.
- `conv_en` is combinational in the accept cycle, with zero latency to the engines.
- A tag appears on `win_*` exactly PIPE_LAT cycles after its accept cycle.
- Gaps in `s_valid` propagate as gaps in `win_valid` with identical spacing.
- The last accept occurs at cycle T. FSM is in FLUSH for cycles T+1..T+PIPE_LAT. `win_eof` fires at T+PIPE_LAT. `done` fires at T+PIPE_LAT+1, one cycle after `win_eof`. `busy` falls at T+PIPE_LAT+2.
- Minimum gap from `done` to next accepted pixel is 2 cycles: `start` in IDLE, then RUN.
- Asynchronous reset mid-frame clears everything immediately. Tags in flight are discarded.

## Test plan
All scenarios use IMG_W=8, IMG_H=6, K=5, PIPE_LAT=3 unless noted.
- Continuous frame: `start`, then `s_valid`=1 for 48 cycles → exactly 8 `win_valid` pulses.
  - `win_sof` is 3 cycles after the accept of pixel (4,4).
  - `win_eol` fires twice and `win_eof` once.
  - `done` is 1 cycle after `win_eof`; `busy` then returns to 0.
- Bubbly input: random 50% `s_valid` → same 8 tags, each 3 cycles after its pixel's accept. No tag appears in a non-accept-aligned cycle. x/y stall during gaps.
- Back-to-back frames: `start` on the cycle after IDLE re-entry → second frame produces identical tag timing relative to its first accept. `start` held during RUN has no effect.
- Abort at pixel (6,4) with a tag in flight → `win_valid`=0 from the next cycle. State is IDLE, x=y=0, no `done`. A fresh `start` produces a full correct frame.
- Async reset asserted mid-FLUSH → all outputs return to reset values without a clock edge. `done` never pulses.
- Boundary config IMG_W=IMG_H=K=5, PIPE_LAT=1 → exactly one `win_valid`, with `win_sof`, `win_eol` and `win_eof` all high, 1 cycle after the 25th accept.

Source files
------------

// File: rtl/conv5x5_frame_ctrl.sv
// conv5x5_frame_ctrl
//   Frame sequencer for the per-channel 5x5 convolution engines. Accepts the
//   pixel stream through a valid/ready handshake and drives the engines'
//   data_valid strobe (conv_en). It tracks the raster position of the next
//   pixel and produces a window-valid tag. The tag is delayed to line up
//   with the engines' fixed pipeline latency. Pixel data does not pass
//   through this block.
//
// Ports
//   clock     in   sole clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   one-cycle frame start request, sampled only in IDLE
//   abort     in   synchronous abort, back to IDLE from any state
//   s_valid   in   upstream pixel valid
//   s_ready   out  block can accept a pixel (RUN only)
//   conv_en   out  s_valid & s_ready, data_valid strobe to the engines
//   win_valid out  engine result of this cycle comes from a full 5x5 window
//   win_sof   out  first win_valid of the frame
//   win_eol   out  last win_valid of each output line
//   win_eof   out  last win_valid of the frame
//   x, y      out  raster position of the next pixel to be accepted
//   busy      out  state != IDLE
//   done      out  one-cycle pulse at frame completion
module conv5x5_frame_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int K        = 5,
  parameter int CW       = 12,
  parameter int PIPE_LAT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          conv_en,
  output logic          win_valid,
  output logic          win_sof,
  output logic          win_eol,
  output logic          win_eof,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int            FW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] K_M1   = CW'(K - 1);
  localparam logic [CW-1:0] ONE_XY = CW'(1);
  localparam logic [FW-1:0] F_LAST = FW'(PIPE_LAT - 1);
  localparam logic [FW-1:0] ONE_F  = FW'(1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CW-1:0]            r_x;
  logic [CW-1:0]            r_y;
  logic [FW-1:0]            r_flush_cnt;
  logic [PIPE_LAT-1:0][3:0] r_pipe;

  logic                     w_accept;
  logic                     w_x_last;
  logic                     w_y_last;
  logic                     w_v;
  logic [3:0]               w_tag;

  assign conv_en  = s_valid & s_ready;
  assign w_accept = conv_en;
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  // Tag from the pre-increment position; only fully populated windows are valid.
  assign w_v   = w_accept & (r_x >= K_M1) & (r_y >= K_M1);
  assign w_tag = {w_v,
                  w_v & (r_x == K_M1) & (r_y == K_M1),
                  w_v & w_x_last,
                  w_v & w_x_last & w_y_last};

  assign x = r_x;
  assign y = r_y;
  assign {win_valid, win_sof, win_eol, win_eof} = r_pipe[PIPE_LAT-1];

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition, including start.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = start ? ST_RUN : ST_IDLE;
        ST_RUN:   w_state_nxt = (w_accept & w_x_last & w_y_last) ? ST_FLUSH : ST_RUN;
        ST_FLUSH: w_state_nxt = (r_flush_cnt == F_LAST) ? ST_DONE : ST_FLUSH;
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_ready = 1'b0;
      end
      ST_RUN: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      ST_FLUSH: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

  // Raster position; the last pixel wraps both counters back to the origin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (abort || ((r_state == ST_IDLE) && start)) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : (r_y + ONE_XY);
      end else begin
        r_x <= r_x + ONE_XY;
      end
    end else begin
      r_x <= r_x;
      r_y <= r_y;
    end
  end

  // Counts FLUSH cycles so the last tag drains before DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flush_cnt <= '0;
    end else if (abort || (r_state != ST_FLUSH)) begin
      r_flush_cnt <= '0;
    end else if (r_flush_cnt == F_LAST) begin
      r_flush_cnt <= '0;
    end else begin
      r_flush_cnt <= r_flush_cnt + ONE_F;
    end
  end

  // Tag delay line matching the engine latency; idle cycles shift in zeros.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pipe <= '0;
    end else if (abort) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_tag;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_conv5x5_frame_ctrl.sv
// Self-checking bench for conv5x5_frame_ctrl. Instance a uses an 8x6 frame
// with PIPE_LAT=3; instance b uses the 5x5, PIPE_LAT=1 corner configuration.
// Expected tags are pushed into a queue at accept time and popped when the
// DUT raises win_valid.
module tb_conv5x5_frame_ctrl;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int KK   = 5;
  localparam int LAT  = 3;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - KK + 1) * (H - KK + 1);

  typedef struct {
    int         cyc;
    logic [2:0] f;
  } tag_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_a = 1'b0, abort_a = 1'b0, s_valid_a = 1'b0;
  logic        s_ready_a, conv_en_a, win_valid_a, win_sof_a, win_eol_a, win_eof_a;
  logic        busy_a, done_a;
  logic [11:0] x_a, y_a;
  logic        start_b = 1'b0, abort_b = 1'b0, s_valid_b = 1'b0;
  logic        s_ready_b, conv_en_b, win_valid_b, win_sof_b, win_eol_b, win_eof_b;
  logic        busy_b, done_b;
  logic [11:0] x_b, y_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_done_cyc = -1;
  logic m_acc = 1'b0;
  int   nwin = 0, nsof = 0, neol = 0, neof = 0, nwin_b = 0;
  tag_t q[$];

  conv5x5_frame_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK), .CW(12), .PIPE_LAT(LAT)) u_dut_a (
    .clock(clock), .reset(rst_n), .start(start_a), .abort(abort_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .conv_en(conv_en_a),
    .win_valid(win_valid_a), .win_sof(win_sof_a), .win_eol(win_eol_a), .win_eof(win_eof_a),
    .x(x_a), .y(y_a), .busy(busy_a), .done(done_a)
  );

  conv5x5_frame_ctrl #(.IMG_W(5), .IMG_H(5), .K(5), .CW(12), .PIPE_LAT(1)) u_dut_b (
    .clock(clock), .reset(rst_n), .start(start_b), .abort(abort_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .conv_en(conv_en_b),
    .win_valid(win_valid_b), .win_sof(win_sof_b), .win_eol(win_eol_b), .win_eof(win_eof_b),
    .x(x_b), .y(y_b), .busy(busy_b), .done(done_b)
  );

  always #5 clock = ~clock;

  // Cycle index: inputs driven after posedge k are captured at posedge k+1.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Per-cycle monitor for instance a (plus a pulse counter for instance b).
  always @(negedge clock) begin
    tag_t e;
    check_eq("conv_en", 32'(conv_en_a), 32'(m_acc));
    check_eq("done", 32'(done_a), 32'(cyc == exp_done_cyc));
    if (win_valid_b) nwin_b++;
    if (win_valid_a) begin
      nwin++;
      if (win_sof_a) nsof++;
      if (win_eol_a) neol++;
      if (win_eof_a) neof++;
      if (q.size() == 0) begin
        check_eq("tag_spurious", 32'(win_valid_a), 32'd0);
      end else begin
        e = q.pop_front();
        check_eq("tag_cycle", cyc, e.cyc);
        check_eq("tag_flags", 32'({win_sof_a, win_eol_a, win_eof_a}), 32'(e.f));
      end
    end else begin
      check_eq("idle_flags", 32'({win_sof_a, win_eol_a, win_eof_a}), 32'd0);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        check_eq("tag_missing", 32'(win_valid_a), 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic push_tag(input int px, input int py, input int t);
    tag_t e;
    if (px >= KK - 1 && py >= KK - 1) begin
      e.cyc = t + LAT;
      e.f   = {(px == KK - 1) && (py == KK - 1), px == W - 1, (px == W - 1) && (py == H - 1)};
      q.push_back(e);
    end
  endtask

  task automatic wait_to(input int n);
    do @(negedge clock); while (cyc < n);
  endtask

  task automatic do_start();
    @(posedge clock); #1;
    start_a = 1'b1;
  endtask

  // Feeds npix pixels to instance a (RUN assumed from the first cycle).
  task automatic feed(input bit bubbly, input int hold_start, input int npix, output int t_last);
    int n = 0;
    int guard = 0;
    t_last = cyc;
    while (n < npix && guard < 5000) begin
      @(posedge clock); #1;
      guard++;
      start_a = (hold_start > 0);
      if (hold_start > 0) hold_start--;
      s_valid_a = bubbly ? 1'($urandom_range(0, 1)) : 1'b1;
      m_acc = s_valid_a;
      if (s_valid_a) begin
        check_eq("x_pos", 32'(x_a), n % W);
        check_eq("y_pos", 32'(y_a), n / W);
        push_tag(n % W, n / W, cyc);
        t_last = cyc;
        n++;
      end
    end
    if (n < npix) check_eq("feed_timeout", n, npix);
    if (npix == NPIX) begin
      // First FLUSH cycle: a pending s_valid must not be accepted.
      @(posedge clock); #1;
      start_a = 1'b0; s_valid_a = 1'b1; m_acc = 1'b0;
      @(posedge clock); #1;
      s_valid_a = 1'b0;
    end
  endtask

  task automatic finish_frame(input int t, input bit b2b);
    exp_done_cyc = t + LAT + 1;
    wait_to(t + LAT + 1);
    check_eq("busy_at_done", 32'(busy_a), 32'd1);
    @(posedge clock); #1;
    start_a = b2b;
    @(negedge clock);
    check_eq("busy_after", 32'(busy_a), 32'd0);
    check_eq("ready_idle", 32'(s_ready_a), 32'd0);
  endtask

  task automatic frame_counts(input int bw, input int bs, input int be, input int bf);
    check_eq("win_count", nwin - bw, NWIN);
    check_eq("sof_count", nsof - bs, 1);
    check_eq("eol_count", neol - be, H - KK + 1);
    check_eq("eof_count", neof - bf, 1);
    check_eq("queue_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, a_cyc, bw, bs, be, bf;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_ready", 32'(s_ready_a), 32'd0);
    check_eq("rst_win", 32'({win_valid_a, win_sof_a, win_eol_a, win_eof_a}), 32'd0);
    check_eq("rst_xy", 32'({x_a, y_a}), 32'd0);
    repeat (2) @(negedge clock);
    #2 rst_n = 1'b1;

    // Continuous frame, then back-to-back frame with start held into RUN.
    bw = nwin; bs = nsof; be = neol; bf = neof;
    do_start();
    feed(1'b0, 0, NPIX, t);
    finish_frame(t, 1'b1);
    frame_counts(bw, bs, be, bf);
    bw = nwin; bs = nsof; be = neol; bf = neof;
    feed(1'b0, 5, NPIX, t);
    finish_frame(t, 1'b0);
    frame_counts(bw, bs, be, bf);

    // Bubbly input.
    bw = nwin; bs = nsof; be = neol; bf = neof;
    do_start();
    feed(1'b1, 0, NPIX, t);
    finish_frame(t, 1'b0);
    frame_counts(bw, bs, be, bf);

    // Abort while pixel (6,4) is presented and earlier tags are in flight.
    do_start();
    feed(1'b0, 0, 4 * W + 6, t);
    @(posedge clock); #1;
    s_valid_a = 1'b1; abort_a = 1'b1; m_acc = 1'b1;
    a_cyc = cyc;
    while (q.size() > 0 && q[$].cyc > a_cyc) void'(q.pop_back());
    @(posedge clock); #1;
    s_valid_a = 1'b0; abort_a = 1'b0; m_acc = 1'b0;
    check_eq("abort_busy", 32'(busy_a), 32'd0);
    check_eq("abort_xy", 32'({x_a, y_a}), 32'd0);
    check_eq("abort_win", 32'(win_valid_a), 32'd0);
    repeat (4) begin
      @(negedge clock);
      check_eq("abort_win_hold", 32'(win_valid_a), 32'd0);
    end
    bw = nwin; bs = nsof; be = neol; bf = neof;
    do_start();
    feed(1'b0, 0, NPIX, t);
    finish_frame(t, 1'b0);
    frame_counts(bw, bs, be, bf);

    // Asynchronous reset in the middle of FLUSH.
    do_start();
    feed(1'b0, 0, NPIX, t);
    rst_n = 1'b0;
    q.delete();
    #1;
    check_eq("arst_busy", 32'(busy_a), 32'd0);
    check_eq("arst_win", 32'({win_valid_a, win_sof_a, win_eol_a, win_eof_a}), 32'd0);
    check_eq("arst_done", 32'(done_a), 32'd0);
    check_eq("arst_xy", 32'({x_a, y_a}), 32'd0);
    @(negedge clock);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clock);
    check_eq("arst_idle", 32'(busy_a), 32'd0);

    // Corner configuration 5x5, PIPE_LAT=1.
    @(posedge clock); #1;
    start_b = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(posedge clock); #1;
      start_b = 1'b0;
      s_valid_b = 1'b1;
      t = cyc;
    end
    @(negedge clock);
    check_eq("b_before", 32'(win_valid_b), 32'd0);
    @(posedge clock); #1;
    s_valid_b = 1'b0;
    @(negedge clock);
    check_eq("b_tag", 32'({win_valid_b, win_sof_b, win_eol_b, win_eof_b}), 32'hF);
    @(negedge clock);
    check_eq("b_done", 32'(done_b), 32'd1);
    @(negedge clock);
    check_eq("b_busy", 32'(busy_b), 32'd0);
    repeat (3) @(negedge clock);
    check_eq("b_count", nwin_b, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
